// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm consumer path: time format, FSM states, counter sizing.
// Latency: none (package only).
// Backpressure: not applicable.
package alarm_pkg;

  localparam int DIGIT_W      = 4;            // one BCD digit
  localparam int TIME_W       = 4 * DIGIT_W;  // {H1,H0,M1,M0}
  localparam int SECS_PER_MIN = 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  // Counter width able to hold terminal-1, never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/alarm_timeout_counter.sv
// Tick counter that pulses done on the TERMINAL-th tick since the last clear.
// Latency: done is combinational with the terminal tick; count updates on the next edge.
// Backpressure: none; clear dominates tick, count saturates at TERMINAL-1.
//
// Ports: clk, reset (sync, active-low), clear (zero the count), tick (count one),
//        done (pulse when a tick arrives with the count at TERMINAL-1).
module alarm_timeout_counter
  import alarm_pkg::*;
#(
  parameter int TERMINAL = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int              CW   = cnt_width(TERMINAL);
  localparam logic [CW-1:0]   LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign done      = tick & ~clear & w_at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick && !w_at_last) begin
      // Hold at LAST: the owner leaves the counting state on done anyway.
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm consumer: fires buzzer on alarm/time match edge, with stop, auto-timeout and optional snooze.
// Latency: alarm/snoozing registered, one cycle after the causing input.
// Backpressure: none; level inputs sampled every cycle, priority stop > snooze > timeout.
//
// Ports: clk, reset (sync, active-low), one_sec (1 s pulse), alarm_data/current_time (BCD HH:MM),
//        alarm_on, stop_alarm, snooze (levels); alarm, snoozing (registered outputs).
// Build option: define ALARM_SNOOZE_EN to include the snooze state and its counter.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_sec,
  input  logic [TIME_W-1:0] alarm_data,
  input  logic [TIME_W-1:0] current_time,
  input  logic              alarm_on,
  input  logic              stop_alarm,
  input  logic              snooze,
  output logic              alarm,
  output logic              snoozing
);

  localparam int SNZ_TERMINAL = SNOOZE_MINUTES * SECS_PER_MIN;

  state_t r_state;
  state_t w_next;
  logic   r_match_q;
  logic   r_alarm;
  logic   w_match;
  logic   w_match_rise;
  logic   w_ring_done;
  logic   w_snz_done;
  logic   w_snooze_req;

  assign w_match      = (current_time == alarm_data);
  assign w_match_rise = w_match & ~r_match_q;

  // Counters only run while in their own state, so a one_sec on the entry
  // cycle is not counted and re-entry always starts from zero.
  alarm_timeout_counter #(.TERMINAL(RING_SECONDS)) u_ring_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != RINGING),
    .tick  (one_sec & (r_state == RINGING)),
    .done  (w_ring_done)
  );

`ifdef ALARM_SNOOZE_EN
  logic r_snoozing;

  alarm_timeout_counter #(.TERMINAL(SNZ_TERMINAL)) u_snz_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != SNOOZE),
    .tick  (one_sec & (r_state == SNOOZE)),
    .done  (w_snz_done)
  );

  assign w_snooze_req = snooze;
  assign snoozing     = r_snoozing;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snoozing <= 1'b0;
    end else begin
      r_snoozing <= (w_next == SNOOZE);
    end
  end
`else
  logic w_unused_snz;

  assign w_unused_snz = snooze ^ (SNZ_TERMINAL > 0);
  assign w_snz_done   = 1'b0;
  assign w_snooze_req = 1'b0;
  assign snoozing     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (!alarm_on) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = ARMED;
        ARMED:   if (w_match_rise) w_next = RINGING;
        RINGING: begin
          if (stop_alarm)        w_next = ARMED;
          else if (w_snooze_req) w_next = SNOOZE;
          else if (w_ring_done)  w_next = ARMED;
        end
        SNOOZE: begin
          if (stop_alarm)       w_next = ARMED;
          else if (w_snz_done)  w_next = RINGING;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // match_q resets high so an alarm time already equal at reset cannot fire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_match_q <= 1'b1;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_match_q <= w_match;
      r_alarm   <= (w_next == RINGING);
    end
  end

  assign alarm = r_alarm;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed table-driven bench for alarm_controller (RING_SECONDS=3, SNOOZE_MINUTES=1).
// Latency: each vector is applied before a rising edge and checked 1 time unit after it.
// Backpressure: not applicable.
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        one_sec;
  logic [15:0] alarm_data;
  logic [15:0] current_time;
  logic        alarm_on;
  logic        stop_alarm;
  logic        snooze;
  logic        alarm;
  logic        snoozing;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alarm_controller #(
    .RING_SECONDS   (3),
    .SNOOZE_MINUTES (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .one_sec      (one_sec),
    .alarm_data   (alarm_data),
    .current_time (current_time),
    .alarm_on     (alarm_on),
    .stop_alarm   (stop_alarm),
    .snooze       (snooze),
    .alarm        (alarm),
    .snoozing     (snoozing)
  );

  typedef struct {
    logic        rst_n;
    logic        on;
    logic        sec;
    logic        stop;
    logic        snz;
    logic [15:0] adata;
    logic [15:0] ctime;
    logic        exp_alarm;
    logic        exp_snoozing;
  } vec_t;

  localparam int NVEC = 35;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic r, logic on, logic sec, logic stop, logic snz,
                              logic [15:0] ad, logic [15:0] ct, logic ea, logic es);
    vec_t v;
    v.rst_n = r; v.on = on; v.sec = sec; v.stop = stop; v.snz = snz;
    v.adata = ad; v.ctime = ct; v.exp_alarm = ea; v.exp_snoozing = es;
    return v;
  endfunction

  task automatic check(input string name, input logic ea, input logic es);
    vec_cnt++;
    if (alarm !== ea || snoozing !== es) begin
      err_cnt++;
      $display("FAIL %s: alarm=%b snoozing=%b, expected alarm=%b snoozing=%b",
               name, alarm, snoozing, ea, es);
    end
  endtask

  task automatic drive(input logic r, input logic on, input logic sec, input logic stop,
                       input logic snz, input logic [15:0] ad, input logic [15:0] ct);
    reset = r; alarm_on = on; one_sec = sec; stop_alarm = stop; snooze = snz;
    alarm_data = ad; current_time = ct;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              rst on sec stp snz adata     ctime     alm snzg
    tbl[0]  = mk(0, 0, 0, 0, 0, 16'h0730, 16'h0729, 0, 0); // reset state
    tbl[1]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0729, 0, 0); // IDLE -> ARMED
    tbl[2]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0); // match edge fires
    tbl[3]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[4]  = mk(1, 1, 0, 1, 0, 16'h0730, 16'h0730, 0, 0); // stop
    tbl[5]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0); // same minute: no re-fire
    tbl[6]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0); // recurs: fires again
    tbl[8]  = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 1, 0); // pulse 1
    tbl[9]  = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[10] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 1, 0); // pulse 2: still ringing
    tbl[11] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 0, 0); // pulse 3: auto-off
    tbl[12] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[13] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 1, 0); // entry pulse not counted
    tbl[14] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[16] = mk(1, 1, 1, 0, 0, 16'h0730, 16'h0730, 0, 0); // third counted pulse
    tbl[17] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 16'h0730, 16'h0730, 0, 0); // disable while ringing
    tbl[20] = mk(1, 0, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[21] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[22] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0);
    tbl[23] = mk(1, 1, 0, 1, 1, 16'h0730, 16'h0730, 0, 0); // stop beats snooze
    tbl[24] = mk(0, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0); // reset while equal
    tbl[25] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0); // no fire after release
    tbl[26] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0);
    tbl[27] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[28] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 1, 0); // next match edge fires
    tbl[29] = mk(0, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0); // reset mid-ring
    tbl[30] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0730, 0, 0);
    tbl[31] = mk(1, 1, 0, 0, 0, 16'h0730, 16'h0731, 0, 0);
    tbl[32] = mk(1, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0);
    tbl[33] = mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0); // 00:00 is a valid alarm
    tbl[34] = mk(1, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst_n, tbl[i].on, tbl[i].sec, tbl[i].stop, tbl[i].snz,
            tbl[i].adata, tbl[i].ctime);
      check($sformatf("vec%0d", i), tbl[i].exp_alarm, tbl[i].exp_snoozing);
    end

    // Snooze sequence: ring at 00:00, then request snooze.
    drive(1, 1, 0, 0, 0, 16'h0000, 16'h0001);
    drive(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
    check("snz_ring", 1'b1, 1'b0);
    drive(1, 1, 0, 0, 1, 16'h0000, 16'h0000);
`ifdef ALARM_SNOOZE_EN
    check("snz_enter", 1'b0, 1'b1);
    for (int p = 1; p <= 59; p++) begin
      drive(1, 1, 1, 0, 0, 16'h0000, 16'h0000);
      drive(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
    end
    check("snz_59", 1'b0, 1'b1);
    drive(1, 1, 1, 0, 0, 16'h0000, 16'h0000);
    check("snz_60", 1'b1, 1'b0);
    drive(1, 1, 0, 0, 1, 16'h0000, 16'h0000);
    check("snz_again", 1'b0, 1'b1);
    drive(1, 1, 0, 1, 0, 16'h0000, 16'h0000);
    check("snz_stop", 1'b0, 1'b0);
`else
    check("snz_ignored", 1'b1, 1'b0);
    drive(1, 1, 0, 0, 1, 16'h0000, 16'h0000);
    check("snz_ignored2", 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
